// File: rtl/id_serializer_pkg.sv
// Shared types and constants for the ID-stage serialiser.
package id_pkg;

  // Sequencer states: IDLE passes instructions, DRAIN feeds bubbles while the
  // pipeline empties, NOTIFY raises the optional syscall pulse, RELEASE gives
  // fetch one free cycle before normal issue resumes.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_NOTIFY  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int DEF_BUBBLES   = 4;
  localparam int DEF_NUM_CLASS = 2;

  // Class indices within Serial_Req_IN / Class_OUT.
  localparam int CLS_SYSCALL = 0;
  localparam int CLS_LLSC    = 1;

endpackage

// File: rtl/id_serializer_counter.sv
// Down-counter for the DRAIN phase: load, decrement, terminal-count flag.
module bubble_counter #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  // Terminal count is 1: the last DRAIN cycle, after which the count reaches 0.
  assign o_tc    = (r_count == W'(1));

endmodule

// File: rtl/id_serializer.sv
// ID-stage serialiser: turns a serialising instruction into a tagged no-op,
// drains the pipeline with bubbles, optionally notifies, then releases.
//
// Handshake: there is no valid/ready pair here; each cycle exactly one of
// Pass_Instr_OUT / Pass_Serial_OUT / Bubble_OUT selects what the ID/EXE
// register loads, and WANT_FREEZE tells fetch to hold the current PC.
module id_serializer
  import id_pkg::*;
#(
  parameter int                   BUBBLES     = DEF_BUBBLES,
  parameter int                   NUM_CLASS   = DEF_NUM_CLASS,
  parameter logic [NUM_CLASS-1:0] NOTIFY_MASK = NUM_CLASS'(1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 Instr_Valid_IN,
  input  logic [NUM_CLASS-1:0] Serial_Req_IN,
  input  logic                 Fwd_Stall_IN,
  input  logic                 Force_Freeze_IN,
  output logic                 Pass_Instr_OUT,
  output logic                 Pass_Serial_OUT,
  output logic                 Bubble_OUT,
  output logic                 SYS_OUT,
  output logic [NUM_CLASS-1:0] Class_OUT,
  output logic [3:0]           Count_OUT,
  output logic                 WANT_FREEZE,
  output state_t               State_DBG
);

  localparam int CW = $clog2(BUBBLES);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_CLASS-1:0] r_class;
  logic [NUM_CLASS-1:0] w_class_nxt;
  logic [NUM_CLASS-1:0] w_lowest;
  logic                 r_sys;
  logic                 w_arm;
  logic                 w_load;
  logic                 w_dec;
  logic                 w_tc;
  logic [CW-1:0]        w_count;

  // Lowest-index set request bit wins when several classes are flagged.
  always_comb begin
    w_lowest = '0;
    for (int i = NUM_CLASS - 1; i >= 0; i--) begin
      if (Serial_Req_IN[i]) begin
        w_lowest    = '0;
        w_lowest[i] = 1'b1;
      end
    end
  end

  assign w_arm = Instr_Valid_IN & (|Serial_Req_IN);

  // Next-state, counter control and ID/EXE load selection.
  always_comb begin
    w_state_nxt     = r_state;
    w_class_nxt     = r_class;
    w_load          = 1'b0;
    w_dec           = 1'b0;
    Pass_Instr_OUT  = 1'b0;
    Pass_Serial_OUT = 1'b0;
    Bubble_OUT      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_arm) begin
          Pass_Serial_OUT = 1'b1;
          Bubble_OUT      = 1'b0;
          w_load          = 1'b1;
          w_class_nxt     = w_lowest;
          w_state_nxt     = ST_DRAIN;
        end else if (Instr_Valid_IN && !Fwd_Stall_IN) begin
          Pass_Instr_OUT = 1'b1;
          Bubble_OUT     = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_dec = 1'b1;
        if (w_tc) begin
          w_state_nxt = ST_NOTIFY;
        end
      end
      ST_NOTIFY: begin
        w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        // A back-to-back serialising instruction is accepted here so it is
        // not lost while fetch is released.
        if (w_arm) begin
          Pass_Serial_OUT = 1'b1;
          Bubble_OUT      = 1'b0;
          w_load          = 1'b1;
          w_class_nxt     = w_lowest;
          w_state_nxt     = ST_DRAIN;
        end else begin
          w_class_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_class_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched class and registered notification pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_class <= '0;
      r_sys   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_class <= w_class_nxt;
      r_sys   <= (w_state_nxt == ST_NOTIFY) && (|(w_class_nxt & NOTIFY_MASK));
    end
  end

  bubble_counter #(
    .W (CW)
  ) u_bubble_counter (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_load     (w_load),
    .i_load_val (CW'(BUBBLES - 1)),
    .i_dec      (w_dec),
    .o_count    (w_count),
    .o_tc       (w_tc)
  );

  // NOTIFY and RELEASE deliberately override every freeze source.
  assign WANT_FREEZE = (Force_Freeze_IN | Fwd_Stall_IN |
                        ((r_state == ST_IDLE) & w_arm) |
                        (r_state == ST_DRAIN)) &
                       ~((r_state == ST_NOTIFY) | (r_state == ST_RELEASE));

  assign SYS_OUT   = r_sys;
  assign Class_OUT = r_class;
  assign Count_OUT = 4'(w_count);
  assign State_DBG = r_state;

endmodule

// File: tb/tb_id_serializer.sv
// Directed bench for id_serializer (BUBBLES=4, NUM_CLASS=2, mask 'b01).
module tb_id_serializer;
  import id_pkg::*;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [1:0] req;
  logic       stall;
  logic       frz;
  logic       pass_instr;
  logic       pass_serial;
  logic       bubble;
  logic       sys;
  logic [1:0] cls;
  logic [3:0] cnt;
  logic       want_freeze;
  state_t     st_dbg;

  int checks   = 0;
  int failures = 0;

  logic [12:0] exp_q[$];

  id_serializer #(
    .BUBBLES     (4),
    .NUM_CLASS   (2),
    .NOTIFY_MASK (2'b01)
  ) dut (
    .CLK             (clk),
    .RESET           (rst),
    .Instr_Valid_IN  (valid),
    .Serial_Req_IN   (req),
    .Fwd_Stall_IN    (stall),
    .Force_Freeze_IN (frz),
    .Pass_Instr_OUT  (pass_instr),
    .Pass_Serial_OUT (pass_serial),
    .Bubble_OUT      (bubble),
    .SYS_OUT         (sys),
    .Class_OUT       (cls),
    .Count_OUT       (cnt),
    .WANT_FREEZE     (want_freeze),
    .State_DBG       (st_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector: {pi, ps, bu, sys, wf, cls[1:0], cnt[3:0], st[1:0]}
  function automatic logic [12:0] ev(input logic pi, input logic ps, input logic bu,
                                     input logic sy, input logic wf, input logic [1:0] c,
                                     input logic [3:0] n, input state_t s);
    return {pi, ps, bu, sy, wf, c, n, 2'(s)};
  endfunction

  // Scoreboard: pop one expectation and compare against the live outputs.
  task automatic check(input string tag);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {pass_instr, pass_serial, bubble, sys, want_freeze, cls, cnt, 2'(st_dbg)};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
    checks++;
    assert ($onehot({pass_instr, pass_serial, bubble}) === 1'b1) else begin
      failures++;
      $error("FAIL %s_onehot observed=%b expected=one-hot", tag,
             {pass_instr, pass_serial, bubble});
    end
  endtask

  // Driver: apply inputs just after the edge, record expectation, sample at negedge.
  task automatic step(input logic v, input logic [1:0] r, input logic s, input logic f,
                      input logic [12:0] exp, input string tag);
    @(posedge clk);
    #1;
    valid = v;
    req   = r;
    stall = s;
    frz   = f;
    exp_q.push_back(exp);
    @(negedge clk);
    check(tag);
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    req   = 2'b00;
    stall = 1'b0;
    frz   = 1'b0;

    #3;
    exp_q.push_back(ev(0, 0, 1, 0, 0, 2'b00, 4'd0, ST_IDLE));
    check("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Plain instruction flow in IDLE
    step(1, 2'b00, 0, 0, ev(1, 0, 0, 0, 0, 2'b00, 4'd0, ST_IDLE), "idle_pass");
    step(1, 2'b00, 1, 0, ev(0, 0, 1, 0, 1, 2'b00, 4'd0, ST_IDLE), "idle_stall");
    step(0, 2'b00, 0, 1, ev(0, 0, 1, 0, 1, 2'b00, 4'd0, ST_IDLE), "idle_freeze");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 0, 2'b00, 4'd0, ST_IDLE), "idle_empty");

    // Syscall: serial no-op, 3 drain bubbles, notify pulse, release, idle
    step(1, 2'b01, 0, 0, ev(0, 1, 0, 0, 1, 2'b00, 4'd0, ST_IDLE), "sc_arm");
    for (int k = 0; k < 3; k++)
      step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 1, 2'b01, 4'(3 - k), ST_DRAIN), "sc_drain");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 1, 0, 2'b01, 4'd0, ST_NOTIFY), "sc_notify");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 0, 2'b01, 4'd0, ST_RELEASE), "sc_release");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 0, 2'b00, 4'd0, ST_IDLE), "sc_idle");

    // LL/SC flush with external freeze held: no pulse, freeze overridden late
    step(1, 2'b10, 0, 1, ev(0, 1, 0, 0, 1, 2'b00, 4'd0, ST_IDLE), "ll_arm");
    for (int k = 0; k < 3; k++)
      step(0, 2'b00, 0, 1, ev(0, 0, 1, 0, 1, 2'b10, 4'(3 - k), ST_DRAIN), "ll_drain");
    step(0, 2'b00, 0, 1, ev(0, 0, 1, 0, 0, 2'b10, 4'd0, ST_NOTIFY), "ll_notify");
    step(0, 2'b00, 0, 1, ev(0, 0, 1, 0, 0, 2'b10, 4'd0, ST_RELEASE), "ll_release");
    step(0, 2'b00, 0, 1, ev(0, 0, 1, 0, 1, 2'b00, 4'd0, ST_IDLE), "ll_idle");

    // Both classes flagged, request held through drain/notify (must be ignored)
    step(1, 2'b11, 0, 0, ev(0, 1, 0, 0, 1, 2'b00, 4'd0, ST_IDLE), "both_arm");
    for (int k = 0; k < 3; k++)
      step(1, 2'b10, 0, 0, ev(0, 0, 1, 0, 1, 2'b01, 4'(3 - k), ST_DRAIN), "both_drain");
    step(1, 2'b10, 0, 0, ev(0, 0, 1, 1, 0, 2'b01, 4'd0, ST_NOTIFY), "both_notify");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 0, 2'b01, 4'd0, ST_RELEASE), "both_release");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 0, 2'b00, 4'd0, ST_IDLE), "both_idle");

    // Forwarding stall held across the whole sequence
    step(1, 2'b01, 1, 0, ev(0, 1, 0, 0, 1, 2'b00, 4'd0, ST_IDLE), "stl_arm");
    for (int k = 0; k < 3; k++)
      step(0, 2'b00, 1, 0, ev(0, 0, 1, 0, 1, 2'b01, 4'(3 - k), ST_DRAIN), "stl_drain");
    step(0, 2'b00, 1, 0, ev(0, 0, 1, 1, 0, 2'b01, 4'd0, ST_NOTIFY), "stl_notify");
    step(0, 2'b00, 1, 0, ev(0, 0, 1, 0, 0, 2'b01, 4'd0, ST_RELEASE), "stl_release");
    step(0, 2'b00, 1, 0, ev(0, 0, 1, 0, 1, 2'b00, 4'd0, ST_IDLE), "stl_idle");

    // Back-to-back syscalls: re-arm in RELEASE; pulses at relative cycles 4 and 9
    step(1, 2'b01, 0, 0, ev(0, 1, 0, 0, 1, 2'b00, 4'd0, ST_IDLE), "b2b_arm1");
    for (int k = 0; k < 3; k++)
      step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 1, 2'b01, 4'(3 - k), ST_DRAIN), "b2b_drain1");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 1, 0, 2'b01, 4'd0, ST_NOTIFY), "b2b_notify1");
    step(1, 2'b01, 0, 0, ev(0, 1, 0, 0, 0, 2'b01, 4'd0, ST_RELEASE), "b2b_rearm");
    for (int k = 0; k < 3; k++)
      step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 1, 2'b01, 4'(3 - k), ST_DRAIN), "b2b_drain2");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 1, 0, 2'b01, 4'd0, ST_NOTIFY), "b2b_notify2");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 0, 2'b01, 4'd0, ST_RELEASE), "b2b_release");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 0, 2'b00, 4'd0, ST_IDLE), "b2b_idle");

    // Reset mid-drain at count 2 abandons the sequence
    step(1, 2'b01, 0, 0, ev(0, 1, 0, 0, 1, 2'b00, 4'd0, ST_IDLE), "rst_arm");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 1, 2'b01, 4'd3, ST_DRAIN), "rst_drain3");
    step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 1, 2'b01, 4'd2, ST_DRAIN), "rst_drain2");
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(ev(0, 0, 1, 0, 0, 2'b00, 4'd0, ST_IDLE));
    check("rst_async");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++)
      step(0, 2'b00, 0, 0, ev(0, 0, 1, 0, 0, 2'b00, 4'd0, ST_IDLE), "rst_quiet");

    if (exp_q.size() != 0) begin
      failures++;
      $error("FAIL leftover observed=%0d expected=0", exp_q.size());
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
